// File: rtl/fifo_pkg.sv
// Shared types and default widths for the FIFO read-side stream engine.
// Pure declarations: no latency, no backpressure.
// Imported by the interface, the skid buffer and the top.
package fifo_pkg;

   localparam int DEF_DATA_WIDTH = 16;
   localparam int DEF_CNT_WIDTH  = 16;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      STOP = 2'd2
   } rd_state_e;

endpackage

// File: rtl/fifo_rd_stream_if.sv
// FIFO read port plus downstream valid/ready stream, bundled for the drain engine.
// Wires only: no latency.
// Backpressure is carried by m_ready; the master side owns fifo_rd_en.
interface fifo_rd_stream_if
   import fifo_pkg::*;
#(
   parameter int DATA_WIDTH = DEF_DATA_WIDTH
);
   logic                  fifo_empty;
   logic [DATA_WIDTH-1:0] fifo_data_out;
   logic                  fifo_rd_en;
   logic                  m_valid;
   logic                  m_ready;
   logic [DATA_WIDTH-1:0] m_data;

   modport master (
      input  fifo_empty, fifo_data_out, m_ready,
      output fifo_rd_en, m_valid, m_data
   );

   modport slave (
      output fifo_empty, fifo_data_out, m_ready,
      input  fifo_rd_en, m_valid, m_data
   );
endinterface

// File: rtl/fifo_rd_stream_skid_buf2.sv
// Two-entry circular skid buffer with push/pop/flush.
// Push is visible one cycle later; holds data stable while popped side stalls.
// Caller guarantees no push when full unless a pop happens in the same cycle.
module skid_buf2 #(
   parameter int DATA_WIDTH = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  push,
   input  logic [DATA_WIDTH-1:0] push_dat,
   input  logic                  pop,
   input  logic                  flush,
   output logic                  vld,
   output logic [DATA_WIDTH-1:0] dat,
   output logic [1:0]            cnt
);
   logic [DATA_WIDTH-1:0] mem [2];
   logic                  head;
   logic                  wr_idx;

   // Tail slot sits bcnt entries past head; bcnt==2 wraps back onto head.
   assign wr_idx = head ^ cnt[0];
   assign vld    = (cnt != 2'd0);
   assign dat    = mem[head];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mem[0] <= '0;
         mem[1] <= '0;
         head   <= 1'b0;
         cnt    <= 2'd0;
      end else if (flush) begin
         head <= 1'b0;
         cnt  <= 2'd0;
      end else begin
         if (push) begin
            mem[wr_idx] <= push_dat;
         end
         if (pop) begin
            head <= ~head;
         end
         cnt <= cnt + {1'b0, push} - {1'b0, pop};
      end
   end
endmodule

// File: rtl/fifo_rd_stream.sv
// Drains the synchronous FIFO into a valid/ready stream, with en/stop FSM, flush and word counter.
// First beat 2 cycles after the first fifo_rd_en; 1 word/cycle sustained.
// Reads are throttled so buffered plus in-flight words never exceed 2 under m_ready stalls.
module fifo_rd_stream
   import fifo_pkg::*;
#(
   parameter int DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int CNT_WIDTH  = DEF_CNT_WIDTH
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 en,
   input  logic                 flush,
   fifo_rd_stream_if.master     io,
   output logic [CNT_WIDTH-1:0] word_cnt,
   output logic                 busy
);
   rd_state_e       state_q;
   rd_state_e       state_d;
   logic            inflight;
   logic [1:0]      bcnt;
   logic            buf_vld;
   logic            pop;
   logic            push;
   logic            rd_en;
   logic [2:0]      occ;

   assign pop  = buf_vld & io.m_ready;
   assign push = inflight & ~flush;

   // Slots that stay committed after this cycle's pop; a new read needs one free.
   assign occ   = {1'b0, bcnt} + {2'b00, inflight} - {2'b00, pop};
   assign rd_en = (state_q == RUN) & ~io.fifo_empty & ~flush & (occ < 3'd2);

   assign io.fifo_rd_en = rd_en;
   assign io.m_valid    = buf_vld;
   assign busy          = (state_q != IDLE);

   skid_buf2 #(
      .DATA_WIDTH (DATA_WIDTH)
   ) u_skid (
      .clk      (clk),
      .rst      (rst),
      .push     (push),
      .push_dat (io.fifo_data_out),
      .pop      (pop),
      .flush    (flush),
      .vld      (buf_vld),
      .dat      (io.m_data),
      .cnt      (bcnt)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= IDLE;
         inflight <= 1'b0;
         word_cnt <= '0;
      end else begin
         state_q  <= state_d;
         inflight <= rd_en;
         if (pop) begin
            word_cnt <= word_cnt + 1'b1;
         end
      end
   end

   always_comb begin
      state_d = state_q;
      if (flush) begin
         state_d = en ? RUN : IDLE;
      end else begin
         unique case (state_q)
            IDLE: if (en) state_d = RUN;
            RUN:  if (!en) state_d = STOP;
            STOP: begin
               if (en) begin
                  state_d = RUN;
               end else if (bcnt == 2'd0 && !inflight) begin
                  state_d = IDLE;
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_fifo_rd_stream.sv
// Bench for fifo_rd_stream: behavioural FIFO, scoreboard of words leaving the FIFO,
// and a negedge monitor that checks every delivered beat in order.
module tb_fifo_rd_stream;
   import fifo_pkg::*;

   localparam int DW = 16;
   localparam int CW = 16;

   logic          clk = 1'b0;
   logic          rst;
   logic          en;
   logic          flush;
   logic [CW-1:0] word_cnt;
   logic          busy;

   fifo_rd_stream_if #(.DATA_WIDTH(DW)) io ();

   fifo_rd_stream #(
      .DATA_WIDTH (DW),
      .CNT_WIDTH  (CW)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .en       (en),
      .flush    (flush),
      .io       (io.master),
      .word_cnt (word_cnt),
      .busy     (busy)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Behavioural FIFO: array with write pointer owned by stimulus, read pointer by the model.
   logic [DW-1:0] mem [0:1023];
   int            wr_ptr = 0;
   int            rd_ptr = 0;
   logic [DW-1:0] exp_q [$];

   assign io.fifo_empty = (rd_ptr == wr_ptr);

   always @(posedge clk) begin
      if (io.fifo_rd_en && (rd_ptr != wr_ptr)) begin
         io.fifo_data_out <= mem[rd_ptr];
         exp_q.push_back(mem[rd_ptr]);
         rd_ptr <= rd_ptr + 1;
      end
   end

   // Monitor: every accepted beat must be the oldest word read and not discarded.
   logic [CW-1:0] exp_cnt = '0;
   int            n_pop = 0;
   int            n_rd = 0;
   int            viol = 0;
   logic          stall = 1'b0;
   logic [DW-1:0] stall_dat = '0;
   logic [DW-1:0] w;

   always @(negedge clk) begin
      if (rst) begin
         exp_q.delete();
         exp_cnt = '0;
         stall   = 1'b0;
      end else begin
         if (stall) begin
            checks++;
            if (!io.m_valid || io.m_data !== stall_dat) begin
               errors++;
               $display("FAIL hold: valid=%0b data=%h required data=%h", io.m_valid, io.m_data, stall_dat);
            end
         end
         if (io.m_valid && io.m_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL beat: unexpected data=%h, nothing outstanding", io.m_data);
            end else begin
               w = exp_q.pop_front();
               if (io.m_data !== w) begin
                  errors++;
                  $display("FAIL beat: data=%h required=%h", io.m_data, w);
               end
            end
            exp_cnt = exp_cnt + 1'b1;
            n_pop++;
         end
         if (flush) exp_q.delete();
         stall     = io.m_valid && !io.m_ready && !flush;
         stall_dat = io.m_data;
         if (io.fifo_rd_en && io.fifo_empty) viol++;
         if (io.fifo_rd_en) n_rd++;
      end
   end

   task automatic chk(input string name, input int act, input int req);
      checks++;
      if (act != req) begin
         errors++;
         $display("FAIL %s: got %0d required %0d", name, act, req);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic load(input int base, input int n);
      for (int i = 0; i < n; i++) begin
         mem[wr_ptr] = DW'(base + i);
         wr_ptr = wr_ptr + 1;
      end
   endtask

   task automatic wait_drain(input string name);
      int k = 0;
      while (!(rd_ptr == wr_ptr && exp_q.size() == 0 && !io.m_valid) && k < 3000) begin
         tick(1);
         k++;
      end
      chk(name, int'(k < 3000), 1);
   endtask

   task automatic wait_idle(input string name);
      int k = 0;
      while (busy && k < 200) begin
         tick(1);
         k++;
      end
      chk(name, int'(busy), 0);
   endtask

   int p0, r0, r1, t_rd, k, cons, saved;
   logic [CW-1:0] c0;

   initial begin
      rst = 1'b1; en = 1'b0; flush = 1'b0; io.m_ready = 1'b0;
      #12;
      chk("rst_m_valid", int'(io.m_valid), 0);
      chk("rst_rd_en", int'(io.fifo_rd_en), 0);
      chk("rst_busy", int'(busy), 0);
      chk("rst_word_cnt", int'(word_cnt), 0);
      chk("rst_m_data", int'(io.m_data), 0);
      @(posedge clk); #1 rst = 1'b0;

      // Full-rate burst of eight words.
      load(1, 8);
      io.m_ready = 1'b1;
      p0 = n_pop;
      en = 1'b1;
      k = 0;
      while (!io.fifo_rd_en && k < 20) begin tick(1); k++; end
      t_rd = k;
      while (!io.m_valid && k < 40) begin tick(1); k++; end
      chk("t1_latency", k - t_rd, 2);
      cons = 0;
      for (int i = 0; i < 8; i++) begin
         if (io.m_valid) cons++;
         tick(1);
      end
      chk("t1_throughput", cons, 8);
      wait_drain("t1_drain");
      chk("t1_beats", n_pop - p0, 8);
      chk("t1_word_cnt", int'(word_cnt), 8);
      en = 1'b0;
      wait_idle("t1_idle");

      // Consumer stalled: only two reads may be issued.
      load(1, 4);
      io.m_ready = 1'b0;
      r0 = n_rd; p0 = n_pop;
      en = 1'b1;
      tick(10);
      chk("t2_reads_stalled", n_rd - r0, 2);
      chk("t2_m_valid", int'(io.m_valid), 1);
      chk("t2_m_data", int'(io.m_data), 1);
      io.m_ready = 1'b1;
      wait_drain("t2_drain");
      chk("t2_beats", n_pop - p0, 4);
      chk("t2_word_cnt", int'(word_cnt), 12);
      en = 1'b0;
      wait_idle("t2_idle");

      // Random backpressure over 64 words.
      load(0, 64);
      p0 = n_pop;
      en = 1'b1;
      k = 0;
      while (!(rd_ptr == wr_ptr && exp_q.size() == 0 && !io.m_valid) && k < 3000) begin
         io.m_ready = 1'($urandom % 2);
         tick(1);
         k++;
      end
      chk("t3_done", int'(k < 3000), 1);
      chk("t3_beats", n_pop - p0, 64);
      chk("t3_word_cnt", int'(word_cnt), 76);
      io.m_ready = 1'b1;
      en = 1'b0;
      wait_idle("t3_idle");

      // Drop en with two words buffered; the pop in that cycle admits one more read.
      load(100, 6);
      io.m_ready = 1'b0;
      r0 = n_rd;
      en = 1'b1;
      tick(5);
      p0 = n_pop;
      en = 1'b0;
      io.m_ready = 1'b1;
      tick(1);
      chk("t4_stop_busy", int'(busy), 1);
      wait_idle("t4_idle");
      chk("t4_beats", n_pop - p0, 3);
      chk("t4_reads", n_rd - r0, 3);
      r1 = n_rd;
      tick(5);
      chk("t4_no_rd_idle", n_rd - r1, 0);
      en = 1'b1;
      wait_drain("t4_rest_drain");
      en = 1'b0;
      wait_idle("t4_rest_idle");

      // Flush with two buffered words: both discarded, counter untouched.
      load(200, 6);
      io.m_ready = 1'b0;
      en = 1'b1;
      tick(5);
      c0 = exp_cnt;
      flush = 1'b1;
      tick(1);
      flush = 1'b0;
      chk("t5_valid_after_flush", int'(io.m_valid), 0);
      chk("t5_word_cnt", int'(word_cnt), int'(c0));
      io.m_ready = 1'b1;
      k = 0;
      while (!io.m_valid && k < 20) begin tick(1); k++; end
      chk("t5_next_word", int'(io.m_data), 202);
      wait_drain("t5_drain");

      // Flush while streaming at full rate; the pop in the flush cycle still counts.
      load(300, 10);
      tick(4);
      flush = 1'b1;
      tick(1);
      flush = 1'b0;
      wait_drain("t5b_drain");
      chk("t5b_word_cnt", int'(word_cnt), int'(exp_cnt));

      // Asynchronous reset mid-burst, then resume from the FIFO's current head.
      load(400, 20);
      tick(6);
      #1 rst = 1'b1;
      #1;
      chk("t6_m_valid", int'(io.m_valid), 0);
      chk("t6_rd_en", int'(io.fifo_rd_en), 0);
      chk("t6_busy", int'(busy), 0);
      chk("t6_word_cnt", int'(word_cnt), 0);
      @(posedge clk); #1;
      saved = rd_ptr;
      rst = 1'b0;
      k = 0;
      while (!io.m_valid && k < 20) begin tick(1); k++; end
      chk("t6_resume_word", int'(io.m_data), int'(mem[saved]));
      wait_drain("t6_drain");
      chk("t6_word_cnt_after", int'(word_cnt), int'(exp_cnt));
      en = 1'b0;
      wait_idle("t6_idle");

      chk("rd_en_while_empty", viol, 0);
      chk("scoreboard_empty", exp_q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
